// File: rtl/sort_pkg.sv
// rtl/sort_pkg.sv - shared constants and read FSM states for the sorter feed path
package sort_pkg;

  localparam int SORT_DW        = 16;
  localparam int SORT_FRAME_LEN = 16;

  // Most negative sample value; pads flushed frames so they sort to one end.
  localparam logic [SORT_DW-1:0] SORT_DATA_MIN = {1'b1, {(SORT_DW-1){1'b0}}};

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_WAIT,
    RD_BURST,
    RD_GAP
  } rd_state_t;

endpackage

// File: rtl/pp_frame_buf.sv
// rtl/pp_frame_buf.sv - two-bank frame store with registered read port and full flags
module pp_frame_buf
  import sort_pkg::*;
#(
  parameter int             DW        = SORT_DW,
  parameter int             FRAME_LEN = SORT_FRAME_LEN,
  parameter logic [DW-1:0]  RST_VAL   = SORT_DATA_MIN,
  localparam int            PW        = $clog2(FRAME_LEN)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic          wr_bank,
  input  logic [PW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          set_full,
  input  logic          clr_full,
  input  logic          clr_bank,
  input  logic          rd_en,
  input  logic          rd_bank,
  input  logic [PW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic [1:0]    full
);

  logic [DW-1:0] mem [2][FRAME_LEN];

  // Sample storage; contents are meaningless until the bank is marked full.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_bank][wr_addr] <= wr_data;
  end

  // Registered read; holds the last burst sample between bursts.
  always_ff @(posedge clk) begin
    if (rst)        rd_data <= RST_VAL;
    else if (rd_en) rd_data <= mem[rd_bank][rd_addr];
  end

  // Full flags: set by the write side on the frame's last slot, cleared by the read side.
  always_ff @(posedge clk) begin
    if (rst) begin
      full <= 2'b00;
    end else begin
      if (set_full) full[wr_bank]  <= 1'b1;
      if (clr_full) full[clr_bank] <= 1'b0;
    end
  end

endmodule

// File: rtl/data_sort_feeder.sv
// rtl/data_sort_feeder.sv - frames an irregular sample stream into gap-separated bursts
module data_sort_feeder
  import sort_pkg::*;
#(
  parameter int            DW         = SORT_DW,
  parameter int            FRAME_LEN  = SORT_FRAME_LEN,
  parameter int            GAP_CYCLES = 1,
  parameter logic [DW-1:0] PAD_VAL    = SORT_DATA_MIN
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s_vld,
  input  logic [DW-1:0] s_din,
  output logic          s_rdy,
  input  logic          flush,
  input  logic          sink_rdy,
  output logic          m_vld,
  output logic [DW-1:0] m_dout,
  output logic          m_sof,
  output logic          m_eof,
  output logic          frm_drop
);

  localparam int            PW      = $clog2(FRAME_LEN);
  localparam int            GW      = $clog2(GAP_CYCLES + 1);
  localparam logic [PW-1:0] LAST    = PW'(FRAME_LEN - 1);
  localparam logic [GW-1:0] GAP_MAX = GW'(GAP_CYCLES);

  logic          wb;
  logic [PW-1:0] wptr;
  logic          padding;
  logic          rdy_en;
  logic [1:0]    full;
  logic          xfer;
  logic          wr_en;
  logic          wr_last;
  logic [DW-1:0] wr_data;

  rd_state_t     state, state_nxt;
  logic          rb;
  logic [PW-1:0] rptr;
  logic [GW-1:0] gap_cnt;
  logic          burst;
  logic          rd_last;
  logic          gap_ok;

  assign s_rdy   = rdy_en & ~padding & ~full[wb];
  assign xfer    = s_vld & s_rdy;
  assign wr_en   = xfer | padding;
  assign wr_last = wr_en & (wptr == LAST);
  assign wr_data = padding ? PAD_VAL : s_din;

  assign burst   = (state == RD_BURST);
  assign rd_last = burst & (rptr == LAST);
  assign gap_ok  = (gap_cnt >= GAP_MAX);

  // Write side: pointer, bank select, flush padding and empty-flush diagnostics.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb       <= 1'b0;
      wptr     <= '0;
      padding  <= 1'b0;
      rdy_en   <= 1'b0;
      frm_drop <= 1'b0;
    end else begin
      rdy_en   <= 1'b1;
      frm_drop <= 1'b0;
      if (wr_en) begin
        wptr <= wptr + 1'b1;
        if (wr_last) begin
          wb      <= ~wb;
          padding <= 1'b0;
        end
      end
      // A flush that coincides with the filling transfer targets the next, empty frame.
      if (flush && !padding) begin
        if (wr_last || (wptr == '0 && !xfer)) frm_drop <= 1'b1;
        else                                  padding  <= 1'b1;
      end
    end
  end

  // Read FSM next-state: wait for a full bank, then a ready sink past the gap.
  always_comb begin
    state_nxt = state;
    case (state)
      RD_IDLE:  if (full[rb])          state_nxt = RD_WAIT;
      RD_WAIT:  if (sink_rdy && gap_ok) state_nxt = RD_BURST;
      RD_BURST: if (rptr == LAST)       state_nxt = RD_GAP;
      RD_GAP:   if (gap_ok)             state_nxt = RD_IDLE;
      default:                          state_nxt = RD_IDLE;
    endcase
  end

  // Read side: state, read pointer, gap counter and registered burst flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RD_IDLE;
      rptr    <= '0;
      rb      <= 1'b0;
      gap_cnt <= '0;
      m_vld   <= 1'b0;
      m_sof   <= 1'b0;
      m_eof   <= 1'b0;
    end else begin
      state <= state_nxt;
      m_vld <= burst;
      m_sof <= burst & (rptr == '0);
      m_eof <= rd_last;
      if (burst) rptr <= rptr + 1'b1;
      // Bank is released while eof is on the output, so rb advances at the same time.
      if (m_eof) rb <= ~rb;
      if (state == RD_WAIT && state_nxt == RD_BURST) gap_cnt <= '0;
      else if (!burst && !gap_ok)                    gap_cnt <= gap_cnt + 1'b1;
    end
  end

  pp_frame_buf #(
    .DW        (DW),
    .FRAME_LEN (FRAME_LEN),
    .RST_VAL   (PAD_VAL)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_bank  (wb),
    .wr_addr  (wptr),
    .wr_data  (wr_data),
    .set_full (wr_last),
    .clr_full (m_eof),
    .clr_bank (rb),
    .rd_en    (burst),
    .rd_bank  (rb),
    .rd_addr  (rptr),
    .rd_data  (m_dout),
    .full     (full)
  );

endmodule

// File: tb/tb_data_sort_feeder.sv
// tb/tb_data_sort_feeder.sv - directed self-checking bench for data_sort_feeder
module tb_data_sort_feeder;

  logic        clk;
  logic        rst;
  logic        s_vld;
  logic [15:0] s_din;
  logic        s_rdy;
  logic        flush;
  logic        sink_rdy;
  logic        m_vld;
  logic [15:0] m_dout;
  logic        m_sof;
  logic        m_eof;
  logic        frm_drop;

  int errors = 0;
  int checks = 0;

  data_sort_feeder dut (
    .clk      (clk),
    .rst      (rst),
    .s_vld    (s_vld),
    .s_din    (s_din),
    .s_rdy    (s_rdy),
    .flush    (flush),
    .sink_rdy (sink_rdy),
    .m_vld    (m_vld),
    .m_dout   (m_dout),
    .m_sof    (m_sof),
    .m_eof    (m_eof),
    .frm_drop (frm_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // Output monitor: records every burst sample and burst framing statistics.
  logic [15:0] q_dout [$];
  bit          q_sof  [$];
  bit          q_eof  [$];
  int          burst_cnt, sof_cnt, gap_err, drop_cnt, low_run, last_gap;
  bit          in_burst;

  always @(negedge clk) begin
    if (rst) begin
      q_dout.delete();
      q_sof.delete();
      q_eof.delete();
      burst_cnt = 0;
      sof_cnt   = 0;
      gap_err   = 0;
      drop_cnt  = 0;
      low_run   = 0;
      last_gap  = -1;
      in_burst  = 0;
    end else begin
      if (frm_drop) drop_cnt++;
      if (m_vld) begin
        if (m_sof) begin
          sof_cnt++;
          if (burst_cnt > 0) last_gap = low_run;
          in_burst = 1;
        end
        low_run = 0;
        q_dout.push_back(m_dout);
        q_sof.push_back(m_sof);
        q_eof.push_back(m_eof);
        if (m_eof) begin
          burst_cnt++;
          in_burst = 0;
        end
      end else begin
        low_run++;
        if (in_burst) gap_err++;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    s_vld    = 1'b0;
    s_din    = '0;
    flush    = 1'b0;
    rst      = 1'b1;
    tick(2);
    rst      = 1'b0;
    tick(1);
  endtask

  task automatic send(input logic [15:0] v);
    int n;
    n     = 0;
    s_vld = 1'b1;
    s_din = v;
    while (!s_rdy && n < 200) begin
      tick(1);
      n++;
    end
    if (n >= 200) check("send_timeout", 32'd0, 32'd1);
    tick(1);
    s_vld = 1'b0;
  endtask

  task automatic wait_bursts(input int n, input int budget);
    int c;
    c = 0;
    while (burst_cnt < n && c < budget) begin
      tick(1);
      c++;
    end
    if (c >= budget) check("burst_timeout", burst_cnt, n);
  endtask

  initial begin
    int acc;
    int c;
    logic rdy;

    s_vld    = 1'b0;
    s_din    = '0;
    flush    = 1'b0;
    sink_rdy = 1'b1;

    // Reset state
    rst = 1'b1;
    tick(1);
    check("rst_s_rdy",    s_rdy,    0);
    check("rst_m_vld",    m_vld,    0);
    check("rst_m_dout",   m_dout,   32'h8000);
    check("rst_m_sof",    m_sof,    0);
    check("rst_m_eof",    m_eof,    0);
    check("rst_frm_drop", frm_drop, 0);
    rst = 1'b0;
    tick(1);
    check("rst_s_rdy_after", s_rdy, 1);

    // 1: one back-to-back frame 1..16
    for (int i = 1; i <= 16; i++) send(16'(i));
    wait_bursts(1, 100);
    check("t1_len", q_dout.size(), 16);
    for (int i = 0; i < 16; i++) check("t1_data", q_dout[i], i + 1);
    check("t1_sof_first", q_sof[0], 1);
    check("t1_eof_last",  q_eof[15], 1);
    check("t1_sof_cnt",   sof_cnt, 1);
    check("t1_gaps",      gap_err, 0);

    // 2: 40 samples with random input gaps
    do_reset();
    for (int i = 0; i < 40; i++) begin
      tick($urandom_range(2, 0));
      send(16'(100 + i));
    end
    wait_bursts(2, 300);
    tick(40);
    check("t2_bursts", burst_cnt, 2);
    check("t2_len", q_dout.size(), 32);
    for (int i = 0; i < 32; i++) check("t2_data", q_dout[i], 100 + i);
    check("t2_min_gap", last_gap >= 1, 1);
    check("t2_gaps", gap_err, 0);
    check("t2_s_rdy", s_rdy, 1);

    // 3: partial frame of 5 then flush
    do_reset();
    for (int i = 0; i < 5; i++) send(16'(200 + i));
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    c = 0;
    while (!s_rdy && c < 50) begin
      c++;
      tick(1);
    end
    check("t3_pad_cycles", c, 11);
    wait_bursts(1, 100);
    check("t3_len", q_dout.size(), 16);
    for (int i = 0; i < 16; i++) check("t3_data", q_dout[i], (i < 5) ? 200 + i : 32'h8000);
    check("t3_sof", q_sof[0], 1);
    check("t3_eof", q_eof[15], 1);

    // 4: sink stalled while both banks fill
    do_reset();
    sink_rdy = 1'b0;
    acc      = 0;
    s_vld    = 1'b1;
    s_din    = 16'(300);
    for (int k = 0; k < 45; k++) begin
      rdy = s_rdy;
      tick(1);
      if (rdy) acc++;
      s_din = 16'(300 + acc);
    end
    check("t4_accepted", acc, 32);
    check("t4_s_rdy_blocked", s_rdy, 0);
    check("t4_no_burst", burst_cnt, 0);
    sink_rdy = 1'b1;
    c = 0;
    while (!m_eof && c < 100) begin
      tick(1);
      c++;
    end
    check("t4_eof_seen", m_eof, 1);
    check("t4_rdy_at_eof", s_rdy, 0);
    tick(1);
    check("t4_rdy_after_eof", s_rdy, 1);
    tick(1);
    s_vld = 1'b0;
    wait_bursts(2, 200);
    check("t4_len", q_dout.size(), 32);
    for (int i = 0; i < 32; i++) check("t4_data", q_dout[i], 300 + i);
    check("t4_sof_cnt", sof_cnt, 2);

    // 5: flush of an empty frame, then flush coinciding with the filling transfer
    do_reset();
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    check("t5_drop_pulse", frm_drop, 1);
    tick(1);
    check("t5_drop_low", frm_drop, 0);
    check("t5_s_rdy", s_rdy, 1);
    tick(30);
    check("t5_no_burst", burst_cnt, 0);
    check("t5_drop_cnt", drop_cnt, 1);
    for (int i = 0; i < 15; i++) send(16'(400 + i));
    s_vld = 1'b1;
    s_din = 16'(415);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    s_vld = 1'b0;
    check("t5_coincide_drop", frm_drop, 1);
    wait_bursts(1, 100);
    check("t5_len", q_dout.size(), 16);
    check("t5_first", q_dout[0], 400);
    check("t5_last", q_dout[15], 415);

    // 6: reset in the middle of a burst
    do_reset();
    for (int i = 0; i < 16; i++) send(16'(500 + i));
    c = 0;
    while (!(m_vld && m_dout == 16'd506) && c < 100) begin
      tick(1);
      c++;
    end
    check("t6_reached_7th", m_dout, 506);
    rst = 1'b1;
    tick(1);
    check("t6_m_vld_drop", m_vld, 0);
    tick(1);
    rst = 1'b0;
    tick(30);
    check("t6_no_burst", burst_cnt, 0);
    check("t6_no_vld", q_dout.size(), 0);
    for (int i = 0; i < 16; i++) send(16'(600 + i));
    wait_bursts(1, 100);
    check("t6_len", q_dout.size(), 16);
    check("t6_first", q_dout[0], 600);
    check("t6_sof", q_sof[0], 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
